// File: rtl/sys_rst_pkg.sv
// Shared types and helpers for the SoC reset/boot sequencer.
package sys_rst_pkg;

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_CFG     = 3'd1,
    ST_WAIT_LK = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RUN     = 3'd4,
    ST_FAULT   = 3'd5
  } rst_state_e;

  localparam int unsigned DEF_PLL_CFG_W = 6;
  localparam logic [DEF_PLL_CFG_W-1:0] DEF_PLL_CFG = 6'b000001;

  // Width of one down-counter able to hold the largest of the four phase lengths.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return unsigned'($clog2(m)) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single level signal, clears to 0 on reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sys_reset_sequencer.sv
// Power-on/boot sequencer: holds reset, programs the PLL, waits for lock,
// then releases the reset domains one by one with a fixed stagger.
module sys_reset_sequencer
  import sys_rst_pkg::*;
#(
  parameter int unsigned          NUM_DOM     = 3,
  parameter int unsigned          PLL_CFG_W   = 6,
  parameter logic [PLL_CFG_W-1:0] PLL_CFG_DEF = PLL_CFG_W'(DEF_PLL_CFG),
  parameter int unsigned          HOLD_CYC    = 102,
  parameter int unsigned          SETTLE_CYC  = 16,
  parameter int unsigned          LOCK_TMO    = 4096,
  parameter int unsigned          STAGGER_CYC = 8
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 cfg_ovr_valid,
  input  logic [PLL_CFG_W-1:0] cfg_ovr,
  input  logic                 sw_reboot,
  input  logic                 pll_lock,
  output logic [PLL_CFG_W-1:0] pll_cfg_o,
  output logic [NUM_DOM-1:0]   dom_rst_n_o,
  output logic                 boot_done_o,
  output logic                 fault_o
);

  localparam int unsigned CNT_W = cnt_width(HOLD_CYC, SETTLE_CYC, LOCK_TMO, STAGGER_CYC);
  localparam int unsigned IDX_W = (NUM_DOM > 1) ? unsigned'($clog2(NUM_DOM)) : 1;

  localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LD     = CNT_W'(LOCK_TMO - 1);
  localparam logic [CNT_W-1:0] STAGGER_LD = CNT_W'(STAGGER_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DOM - 1);

  rst_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NUM_DOM-1:0]   dom_q, dom_d;
  logic                 boot_q, boot_d;
  logic                 fault_q, fault_d;
  logic [PLL_CFG_W-1:0] pll_q, pll_d;
  logic [PLL_CFG_W-1:0] latch_q, latch_d;
  logic                 lock_s;

  sync_2ff u_lock_sync (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HOLD;
      cnt_q   <= HOLD_LD;
      idx_q   <= '0;
      dom_q   <= '0;
      boot_q  <= 1'b0;
      fault_q <= 1'b0;
      pll_q   <= PLL_CFG_DEF;
      latch_q <= PLL_CFG_DEF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dom_q   <= dom_d;
      boot_q  <= boot_d;
      fault_q <= fault_d;
      pll_q   <= pll_d;
      latch_q <= latch_d;
    end
  end

  // Next state; priority is sw_reboot, then lock loss, then counter expiry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dom_d   = dom_q;
    boot_d  = boot_q;
    fault_d = fault_q;
    pll_d   = pll_q;
    latch_d = cfg_ovr_valid ? cfg_ovr : latch_q;

    if (sw_reboot && (state_q != ST_HOLD)) begin
      state_d = ST_CFG;
      cnt_d   = SETTLE_LD;
      idx_d   = '0;
      dom_d   = '0;
      boot_d  = 1'b0;
      fault_d = 1'b0;
      pll_d   = latch_d;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_q == '0) begin
            state_d = ST_CFG;
            cnt_d   = SETTLE_LD;
            pll_d   = latch_d;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_CFG: begin
          if (cnt_q == '0) begin
            state_d = ST_WAIT_LK;
            cnt_d   = TMO_LD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_WAIT_LK: begin
          if (lock_s) begin
            state_d = ST_RELEASE;
            idx_d   = '0;
            dom_d   = NUM_DOM'(1);
            cnt_d   = STAGGER_LD;
          end else if (cnt_q == '0) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
            dom_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (!lock_s) begin
            state_d = ST_WAIT_LK;
            cnt_d   = TMO_LD;
            dom_d   = '0;
            boot_d  = 1'b0;
          end else if (idx_q == LAST_IDX) begin
            state_d = ST_RUN;
            boot_d  = 1'b1;
          end else if (cnt_q == '0) begin
            idx_d = idx_q + IDX_W'(1);
            dom_d = dom_q | (NUM_DOM'(1) << idx_d);
            cnt_d = STAGGER_LD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_d = ST_WAIT_LK;
            cnt_d   = TMO_LD;
            dom_d   = '0;
            boot_d  = 1'b0;
          end
        end
        ST_FAULT: begin
          dom_d   = '0;
          fault_d = 1'b1;
        end
        default: begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
          dom_d   = '0;
          boot_d  = 1'b0;
        end
      endcase
    end
  end

  assign pll_cfg_o   = pll_q;
  assign dom_rst_n_o = dom_q;
  assign boot_done_o = boot_q;
  assign fault_o     = fault_q;

endmodule

// File: tb/tb_sys_reset_sequencer.sv
// Bench for sys_reset_sequencer: three parameterisations share one stimulus stream
// and are compared every cycle against an event-time reference model.
module tb_sys_reset_sequencer;

  localparam int HOLD   = 102;
  localparam int SETTLE = 16;
  localparam int TMO    = 4096;
  localparam logic [5:0] CFG_DEF = 6'b000001;

  logic       sys_clk;
  logic       rst_n;
  logic       cfg_ovr_valid;
  logic [5:0] cfg_ovr;
  logic       sw_reboot;
  logic       pll_lock;

  logic [5:0] pll_cfg0, pll_cfg1, pll_cfg2;
  logic [2:0] dom0;
  logic [4:0] dom1;
  logic [0:0] dom2;
  logic       boot0, boot1, boot2;
  logic       fault0, fault1, fault2;

  int passed, total;

  // Reference model: edge count since reset release plus event timestamps (-1 = inactive).
  int         k;
  bit         in_hold;
  int         cfg_end, wait_start, rel0;
  bit         m_fault;
  logic [5:0] m_latch, m_cfg;
  bit         lk_q[$];

  int         d, r;
  logic [5:0] v;
  logic [12:0] ev;

  sys_reset_sequencer #(.NUM_DOM(3), .STAGGER_CYC(8)) dut0 (
    .sys_clk(sys_clk), .rst_n(rst_n), .cfg_ovr_valid(cfg_ovr_valid), .cfg_ovr(cfg_ovr),
    .sw_reboot(sw_reboot), .pll_lock(pll_lock), .pll_cfg_o(pll_cfg0),
    .dom_rst_n_o(dom0), .boot_done_o(boot0), .fault_o(fault0));

  sys_reset_sequencer #(.NUM_DOM(5), .STAGGER_CYC(1)) dut1 (
    .sys_clk(sys_clk), .rst_n(rst_n), .cfg_ovr_valid(cfg_ovr_valid), .cfg_ovr(cfg_ovr),
    .sw_reboot(sw_reboot), .pll_lock(pll_lock), .pll_cfg_o(pll_cfg1),
    .dom_rst_n_o(dom1), .boot_done_o(boot1), .fault_o(fault1));

  sys_reset_sequencer #(.NUM_DOM(1), .STAGGER_CYC(1)) dut2 (
    .sys_clk(sys_clk), .rst_n(rst_n), .cfg_ovr_valid(cfg_ovr_valid), .cfg_ovr(cfg_ovr),
    .sw_reboot(sw_reboot), .pll_lock(pll_lock), .pll_cfg_o(pll_cfg2),
    .dom_rst_n_o(dom2), .boot_done_o(boot2), .fault_o(fault2));

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) begin
      passed = passed + 1;
    end else begin
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, k);
    end
  endtask

  task automatic model_reset();
    k = 0; in_hold = 1'b1; cfg_end = -1; wait_start = -1; rel0 = -1; m_fault = 1'b0;
    m_latch = CFG_DEF; m_cfg = CFG_DEF;
    lk_q.delete(); lk_q.push_back(1'b0); lk_q.push_back(1'b0);
  endtask

  // Applies the sequencing rules to the inputs seen at the current edge.
  task automatic model_edge();
    bit lock_s;
    logic [5:0] nl;
    if (!rst_n) begin
      model_reset();
      return;
    end
    k = k + 1;
    lock_s = lk_q.pop_front();
    lk_q.push_back(pll_lock);
    nl = cfg_ovr_valid ? cfg_ovr : m_latch;
    if (in_hold) begin
      if (k == HOLD) begin in_hold = 1'b0; m_cfg = nl; cfg_end = k + SETTLE; end
    end else if (sw_reboot) begin
      m_cfg = nl; cfg_end = k + SETTLE; wait_start = -1; rel0 = -1; m_fault = 1'b0;
    end else if (cfg_end >= 0) begin
      if (k == cfg_end) begin cfg_end = -1; wait_start = k; end
    end else if (wait_start >= 0) begin
      if (lock_s) begin rel0 = k; wait_start = -1; end
      else if (k == wait_start + TMO) begin m_fault = 1'b1; wait_start = -1; end
    end else if (rel0 >= 0) begin
      if (!lock_s) begin rel0 = -1; wait_start = k; end
    end
    m_latch = nl;
  endtask

  function automatic logic [12:0] exp_out(input int n, input int stg);
    logic [4:0] dm;
    logic b;
    dm = '0;
    for (int i = 0; i < n; i++) dm[i] = (rel0 >= 0) && (k >= rel0 + i * stg);
    b = (rel0 >= 0) && (k >= rel0 + (n - 1) * stg + 1);
    return {m_cfg, dm, b, m_fault};
  endfunction

  task automatic check_all();
    check("dut0_outputs", 32'({pll_cfg0, 5'(dom0), boot0, fault0}), 32'(exp_out(3, 8)));
    check("dut1_outputs", 32'({pll_cfg1, dom1, boot1, fault1}), 32'(exp_out(5, 1)));
    check("dut2_outputs", 32'({pll_cfg2, 5'(dom2), boot2, fault2}), 32'(exp_out(1, 1)));
  endtask

  task automatic tick();
    @(posedge sys_clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 20000 && k < target; i++) tick();
  endtask

  task automatic wait_boot(input string tag);
    ev = exp_out(3, 8);
    for (int i = 0; i < 600 && ev[1] !== 1'b1; i++) begin
      tick();
      ev = exp_out(3, 8);
    end
    check(tag, 32'(boot0), 32'd1);
  endtask

  initial begin
    passed = 0; total = 0;
    rst_n = 1'b0; pll_lock = 1'b0; sw_reboot = 1'b0; cfg_ovr_valid = 1'b0; cfg_ovr = '0;
    model_reset();
    repeat (3) tick();
    check("reset_dom", 32'(dom0), 32'd0);
    check("reset_cfg", 32'(pll_cfg0), 32'(CFG_DEF));
    rst_n = 1'b1;

    // Nominal boot: lock first sampled at edge 168, dom0 expected at 102+16+50+2.
    run_to(167);
    pll_lock = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (k == 169) check("nom_dom0_pre", 32'(dom0), 32'd0);
      if (k == 170) begin
        check("nom_dom0", 32'(dom0), 32'b001);
        check("sw5_dom0", 32'(dom1), 32'b00001);
        check("n1_dom0", 32'(dom2), 32'd1);
      end
      if (k == 171) check("n1_boot", 32'(boot2), 32'd1);
      if (k == 172) check("sw5_spacing", 32'(dom1), 32'b00111);
      if (k == 174) check("sw5_boot_pre", 32'(boot1), 32'd0);
      if (k == 175) check("sw5_boot", 32'(boot1), 32'd1);
      if (k == 177) check("nom_dom1_pre", 32'(dom0), 32'b001);
      if (k == 178) check("nom_dom1", 32'(dom0), 32'b011);
      if (k == 186) check("nom_dom2", 32'({dom0, boot0}), 32'b1110);
      if (k == 187) check("nom_boot", 32'(boot0), 32'd1);
    end

    // Override while running only applies at the next reboot.
    cfg_ovr = 6'b101010; cfg_ovr_valid = 1'b1; tick(); cfg_ovr_valid = 1'b0;
    repeat (4) tick();
    check("ovr_run_hold", 32'(pll_cfg0), 32'(CFG_DEF));
    sw_reboot = 1'b1; tick(); sw_reboot = 1'b0;
    check("ovr_reboot_cfg", 32'(pll_cfg0), 32'b101010);
    check("ovr_reboot_dom", 32'(dom0), 32'd0);
    wait_boot("ovr_boot");
    v = 6'($urandom_range(2, 63));
    if (v == 6'b101010) v = 6'b010101;
    cfg_ovr = v; cfg_ovr_valid = 1'b1; sw_reboot = 1'b1; tick();
    cfg_ovr_valid = 1'b0; sw_reboot = 1'b0;
    check("ovr_same_cycle", 32'(pll_cfg0), 32'(v));
    wait_boot("same_cycle_boot");

    // Lock loss in RUN for 5 cycles.
    repeat (5) tick();
    d = k;
    pll_lock = 1'b0;
    repeat (3) tick();
    check("loss_dom", 32'(dom0), 32'd0);
    check("loss_boot", 32'(boot0), 32'd0);
    repeat (2) tick();
    pll_lock = 1'b1;
    repeat (3) tick();
    check("relock_dom0", 32'(dom0), 32'b001);
    check("relock_cycle", 32'(k - d), 32'd8);
    wait_boot("relock_boot");

    // Random-length lock drops, possibly landing mid-release.
    for (int n = 0; n < 4; n++) begin
      repeat ($urandom_range(0, 20)) tick();
      pll_lock = 1'b0;
      repeat ($urandom_range(1, 6)) tick();
      pll_lock = 1'b1;
      wait_boot("rand_loss_boot");
    end

    // Random mixed stimulus.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0) pll_lock = ~pll_lock;
      sw_reboot = ($urandom_range(0, 149) == 0);
      cfg_ovr_valid = ($urandom_range(0, 19) == 0);
      cfg_ovr = 6'($urandom);
      tick();
    end
    sw_reboot = 1'b0; cfg_ovr_valid = 1'b0;

    // Lock timeout, sticky fault, recovery by reboot.
    pll_lock = 1'b0;
    repeat (3) tick();
    sw_reboot = 1'b1; r = k + 1; tick(); sw_reboot = 1'b0;
    run_to(r + SETTLE + TMO - 1);
    check("tmo_pre", 32'(fault0), 32'd0);
    tick();
    check("tmo_fault", 32'(fault0), 32'd1);
    check("tmo_dom", 32'(dom0), 32'd0);
    check("tmo_fault_n5", 32'(fault1), 32'd1);
    repeat (20) tick();
    check("fault_sticky", 32'(fault0), 32'd1);
    pll_lock = 1'b1; sw_reboot = 1'b1; tick(); sw_reboot = 1'b0;
    check("fault_clear", 32'(fault0), 32'd0);
    wait_boot("fault_recover_boot");

    // Asynchronous reset with dom0 already released.
    sw_reboot = 1'b1; tick(); sw_reboot = 1'b0;
    for (int i = 0; i < 100 && !(rel0 >= 0 && k == rel0 + 2); i++) tick();
    check("mid_release_dom0", 32'(dom0), 32'b001);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check("async_dom", 32'(dom0), 32'd0);
    check("async_cfg", 32'(pll_cfg0), 32'(CFG_DEF));
    repeat (2) tick();
    rst_n = 1'b1;
    run_to(9);
    sw_reboot = 1'b1; tick(); sw_reboot = 1'b0;
    run_to(102);
    check("restart_cfg", 32'(pll_cfg0), 32'(CFG_DEF));
    run_to(118);
    check("restart_dom_pre", 32'(dom0), 32'd0);
    tick();
    check("restart_dom0", 32'(dom0), 32'b001);
    wait_boot("restart_boot");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
